// File: rtl/imm_decode_pkg.sv
// Shared types and opcode constants for the immediate decode stage.
package imm_decode_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP32     = 7'b0111011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_IMM32    = 7'b0011011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    typedef struct packed {
        fmt_e       fmt;
        logic       illegal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } dec_t;

    localparam dec_t DEC_RST = '{fmt: FMT_R, illegal: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0};

endpackage

// File: rtl/imm_decode_stage_if.sv
// Input/output handshake bundle of the decode stage.
interface imm_decode_stage_if #(parameter int XLEN = 32);
    import imm_decode_pkg::*;

    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     in_instr_i;
    logic [XLEN-1:0] in_pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_pc_o;
    fmt_e            out_fmt_o;
    logic [XLEN-1:0] out_imm_o;
    logic [4:0]      out_rd_o;
    logic [4:0]      out_rs1_o;
    logic [4:0]      out_rs2_o;
    logic            out_illegal_o;

    // driver side: produces instructions, consumes decoded entries
    modport master (
        output in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_fmt_o, out_imm_o,
               out_rd_o, out_rs1_o, out_rs2_o, out_illegal_o
    );

    // decode stage side
    modport slave (
        input  in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_fmt_o, out_imm_o,
               out_rd_o, out_rs1_o, out_rs2_o, out_illegal_o
    );

endinterface

// File: rtl/imm_decode_stage_extract.sv
// Combinational format classification and XLEN-wide immediate extraction.
// The sign bit instr[31] is replicated down to bit 31 of the result, so every
// replication count stays positive for both legal XLEN values.
module imm_extract
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output dec_t            dec,
    output logic [XLEN-1:0] imm
);

    logic sgn;
    assign sgn = instr[31];

    // classify opcode and build the sign-extended immediate for its format
    always_comb begin
        dec.fmt     = FMT_R;
        dec.illegal = 1'b0;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        imm         = '0;
        if (instr[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (instr[6:0])
                OP_OP, OP_OP32: dec.fmt = FMT_R;
                OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_IMM32, OP_MISC_MEM: begin
                    dec.fmt = FMT_I;
                    imm     = {{(XLEN-11){sgn}}, instr[30:20]};
                end
                OP_STORE: begin
                    dec.fmt = FMT_S;
                    imm     = {{(XLEN-11){sgn}}, instr[30:25], instr[11:7]};
                end
                OP_BRANCH: begin
                    dec.fmt = FMT_B;
                    imm     = {{(XLEN-12){sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    dec.fmt = FMT_U;
                    imm     = {{(XLEN-31){sgn}}, instr[30:12], 12'b0};
                end
                OP_JAL: begin
                    dec.fmt = FMT_J;
                    imm     = {{(XLEN-20){sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode stage: main register M drives the outputs, skid register
// S absorbs one word so in_ready can come straight from a flop.
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    imm_decode_stage_if.slave bus
);

    dec_t            in_dec;
    logic [XLEN-1:0] in_imm;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr (bus.in_instr_i),
        .dec   (in_dec),
        .imm   (in_imm)
    );

    logic            m_vld, s_vld, rdy_q;
    dec_t            m_dec, s_dec;
    logic [XLEN-1:0] m_imm, s_imm, m_pc, s_pc;
    logic            accept, m_free;

    // a flushed cycle never accepts; M is free when empty or being drained
    assign accept = bus.in_valid_i && rdy_q && !flush_i;
    assign m_free = !m_vld || bus.out_ready_i;

    // occupancy: rdy_q always tracks !s_vld of the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            rdy_q <= 1'b1;
        end else if (flush_i) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            rdy_q <= 1'b1;
        end else if (m_free) begin
            // S refills M first; S full implies no accept this cycle
            m_vld <= s_vld || accept;
            s_vld <= 1'b0;
            rdy_q <= 1'b1;
        end else if (accept) begin
            s_vld <= 1'b1;
            rdy_q <= 1'b0;
        end
    end

    // payload movement; idle entries simply hold their last contents
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_dec <= DEC_RST;
            m_imm <= '0;
            m_pc  <= '0;
            s_dec <= DEC_RST;
            s_imm <= '0;
            s_pc  <= '0;
        end else if (m_free) begin
            if (s_vld) begin
                m_dec <= s_dec;
                m_imm <= s_imm;
                m_pc  <= s_pc;
            end else if (accept) begin
                m_dec <= in_dec;
                m_imm <= in_imm;
                m_pc  <= bus.in_pc_i;
            end
        end else if (accept) begin
            s_dec <= in_dec;
            s_imm <= in_imm;
            s_pc  <= bus.in_pc_i;
        end
    end

    assign bus.in_ready_o    = rdy_q;
    assign bus.out_valid_o   = m_vld;
    assign bus.out_pc_o      = m_pc;
    assign bus.out_fmt_o     = m_dec.fmt;
    assign bus.out_imm_o     = m_imm;
    assign bus.out_rd_o      = m_dec.rd;
    assign bus.out_rs1_o     = m_dec.rs1;
    assign bus.out_rs2_o     = m_dec.rs2;
    assign bus.out_illegal_o = m_dec.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench: drives an XLEN=32 and an XLEN=64 stage with the same stimulus and
// compares both against a two-deep FIFO model with an arithmetic decoder.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32)) if32 ();
    imm_decode_stage_if #(.XLEN(64)) if64 ();

    assign if32.in_valid_i  = in_valid;
    assign if32.in_instr_i  = in_instr;
    assign if32.in_pc_i     = in_pc[31:0];
    assign if32.out_ready_i = out_ready;
    assign if64.in_valid_i  = in_valid;
    assign if64.in_instr_i  = in_instr;
    assign if64.in_pc_i     = in_pc;
    assign if64.out_ready_i = out_ready;

    imm_decode_stage #(.XLEN(32)) dut32 (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(if32.slave));
    imm_decode_stage #(.XLEN(64)) dut64 (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(if64.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // decoder written from the field rules as integer arithmetic
    function automatic void ref_dec(input logic [31:0] w, output int fmt, output bit ill,
                                    output longint imm);
        longint u;
        u   = longint'(w);
        fmt = 0;
        ill = 1'b0;
        imm = 0;
        if (w[1:0] != 2'b11) ill = 1'b1;
        else case (w[6:0])
            7'h33, 7'h3B: fmt = 0;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h0F: begin
                fmt = 1;
                imm = u >> 20;
                if (w[31]) imm -= 4096;
            end
            7'h23: begin
                fmt = 2;
                imm = ((u >> 25) << 5) + ((u >> 7) & 31);
                if (w[31]) imm -= 4096;
            end
            7'h63: begin
                fmt = 3;
                imm = ((u >> 31) << 12) + (((u >> 7) & 1) << 11)
                    + (((u >> 25) & 63) << 5) + (((u >> 8) & 15) << 1);
                if (w[31]) imm -= 8192;
            end
            7'h37, 7'h17: begin
                fmt = 4;
                imm = (u >> 12) << 12;
                if (w[31]) imm -= (longint'(1) << 32);
            end
            7'h6F: begin
                fmt = 5;
                imm = ((u >> 31) << 20) + (((u >> 12) & 255) << 12)
                    + (((u >> 20) & 1) << 11) + (((u >> 21) & 1023) << 1);
                if (w[31]) imm -= (longint'(1) << 21);
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_vld32"}, 64'(if32.out_valid_o), 64'd0);
        chk({tag, "_rdy32"}, 64'(if32.in_ready_o), 64'd1);
        chk({tag, "_imm32"}, 64'(if32.out_imm_o), 64'd0);
        chk({tag, "_pc32"}, 64'(if32.out_pc_o), 64'd0);
        chk({tag, "_fmt32"}, 64'(if32.out_fmt_o), 64'd0);
        chk({tag, "_regs32"}, {49'd0, if32.out_rd_o, if32.out_rs1_o, if32.out_rs2_o}, 64'd0);
        chk({tag, "_ill32"}, 64'(if32.out_illegal_o), 64'd0);
        chk({tag, "_vld64"}, 64'(if64.out_valid_o), 64'd0);
        chk({tag, "_rdy64"}, 64'(if64.in_ready_o), 64'd1);
        chk({tag, "_imm64"}, if64.out_imm_o, 64'd0);
        chk({tag, "_pc64"}, if64.out_pc_o, 64'd0);
    endtask

    // compare both DUTs to the model state at the current point in the cycle
    task automatic check_all();
        int     f;
        bit     ill;
        longint imm;
        chk("out_valid32", 64'(if32.out_valid_o), 64'(q.size() > 0));
        chk("in_ready32", 64'(if32.in_ready_o), 64'(q.size() < 2));
        chk("out_valid64", 64'(if64.out_valid_o), 64'(q.size() > 0));
        chk("in_ready64", 64'(if64.in_ready_o), 64'(q.size() < 2));
        if (q.size() > 0) begin
            ref_dec(q[0].instr, f, ill, imm);
            chk("fmt32", 64'(if32.out_fmt_o), 64'(f));
            chk("ill32", 64'(if32.out_illegal_o), 64'(ill));
            chk("imm32", 64'(if32.out_imm_o), 64'(imm[31:0]));
            chk("pc32", 64'(if32.out_pc_o), 64'(q[0].pc[31:0]));
            chk("rd32", 64'(if32.out_rd_o), 64'(q[0].instr[11:7]));
            chk("rs1_32", 64'(if32.out_rs1_o), 64'(q[0].instr[19:15]));
            chk("rs2_32", 64'(if32.out_rs2_o), 64'(q[0].instr[24:20]));
            chk("fmt64", 64'(if64.out_fmt_o), 64'(f));
            chk("ill64", 64'(if64.out_illegal_o), 64'(ill));
            chk("imm64", if64.out_imm_o, 64'(imm));
            chk("pc64", if64.out_pc_o, q[0].pc);
        end
    endtask

    // check, clock once, then advance the model by what transferred
    task automatic step();
        bit xo, xi;
        check_all();
        xo = (q.size() > 0) && out_ready;
        xi = in_valid && (q.size() < 2);
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (xo) void'(q.pop_front());
            if (xi) q.push_back('{instr: in_instr, pc: in_pc});
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = w;
        in_pc     = {$urandom, $urandom};
        out_ready = rdy;
        flush     = fl;
        step();
    endtask

    logic [6:0] ops [13] = '{7'h33, 7'h3B, 7'h13, 7'h03, 7'h67, 7'h73, 7'h1B,
                             7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    initial begin
        logic [31:0] w;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        drive(0, 32'h0, 1, 0);

        // directed formats, back to back with the consumer always ready
        drive(1, 32'hFFF00093, 1, 0);
        chk("addi_imm32", 64'(if32.out_imm_o), 64'hFFFF_FFFF);
        chk("addi_imm64", if64.out_imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_fmt", 64'(if32.out_fmt_o), 64'd1);
        chk("addi_rd", 64'(if32.out_rd_o), 64'd1);
        drive(1, 32'hFE112E23, 1, 0);
        chk("sw_imm32", 64'(if32.out_imm_o), 64'hFFFF_FFFC);
        chk("sw_fmt", 64'(if32.out_fmt_o), 64'd2);
        chk("sw_rs", {54'd0, if32.out_rs1_o, if32.out_rs2_o}, {54'd0, 5'd2, 5'd1});
        drive(1, 32'h123452B7, 1, 0);
        chk("lui_imm32", 64'(if32.out_imm_o), 64'h1234_5000);
        chk("lui_imm64", if64.out_imm_o, 64'h1234_5000);
        chk("lui_fmt", 64'(if32.out_fmt_o), 64'd4);
        chk("lui_rd", 64'(if32.out_rd_o), 64'd5);
        drive(1, 32'hFF9FF06F, 1, 0);
        chk("jal_imm32", 64'(if32.out_imm_o), 64'hFFFF_FFF8);
        chk("jal_fmt", 64'(if32.out_fmt_o), 64'd5);
        drive(0, 32'h0, 1, 0);

        // backpressure: two words buffered, third held off until drained
        drive(1, 32'h00100093, 0, 0);
        drive(1, 32'h00200093, 0, 0);
        chk("bp_ready", 64'(if32.in_ready_o), 64'd0);
        repeat (3) begin
            drive(1, 32'h00300093, 0, 0);
            chk("bp_hold", 64'(if32.out_imm_o), 64'd1);
        end
        drive(1, 32'h00300093, 1, 0);
        chk("bp_second", 64'(if32.out_imm_o), 64'd2);
        drive(1, 32'h00300093, 1, 0);
        chk("bp_third", 64'(if32.out_imm_o), 64'd3);
        drive(0, 32'h0, 1, 0);

        // illegal encodings are delivered, not dropped
        drive(1, 32'h00000000, 1, 0);
        chk("ill_zero", {62'd0, if32.out_valid_o, if32.out_illegal_o}, 64'd3);
        drive(1, 32'hFFFFFFFF, 1, 0);
        chk("ill_ones", {62'd0, if32.out_valid_o, if32.out_illegal_o}, 64'd3);
        chk("ill_imm", if64.out_imm_o, 64'd0);
        drive(0, 32'h0, 1, 0);

        // flush with both entries full drops the word offered alongside it
        drive(1, 32'h00A00093, 0, 0);
        drive(1, 32'h00B00093, 0, 0);
        drive(1, 32'h00500093, 0, 1);
        chk("flush_vld", {62'd0, if32.out_valid_o, if32.in_ready_o}, 64'd1);
        drive(0, 32'h0, 1, 0);
        drive(0, 32'h0, 1, 0);

        // asynchronous reset between edges with S occupied
        drive(1, 32'h00C00093, 0, 0);
        drive(1, 32'h00D00093, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 32'h00700093, 1, 0);
        chk("post_rst", {63'd0, if32.out_valid_o}, 64'd1);
        chk("post_rst_imm", 64'(if32.out_imm_o), 64'd7);
        drive(0, 32'h0, 1, 0);

        // random traffic with random backpressure and rare flushes
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 12)];
            drive(1'($urandom_range(0, 2) != 0), w, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 24) == 0));
        end
        drive(0, 32'h0, 1, 0);
        drive(0, 32'h0, 1, 0);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
